// File: rtl/lib_pkg.sv
// Shared branch types, FSM states and PC constants for branch_seq.
// Pure declarations: no latency. No backpressure.
// Holds one saturating-counter helper used by the statistics registers.
package lib_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'd0,
        BNE  = 3'd1,
        BLT  = 3'd4,
        BGE  = 3'd5,
        BLTU = 3'd6,
        BGEU = 3'd7
    } cmp_type_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2
    } brseq_state_t;

    localparam int PC_STEP = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cmp.sv
// Branch condition comparator: signed/unsigned compare of two operands.
// Latency: purely combinational. Backpressure: none.
// Encodings outside cmp_type_t resolve to not-taken.
module cmp
    import lib_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  cmp_type_t          cmp_type,
    input  logic [WIDTH-1:0]   rs1,
    input  logic [WIDTH-1:0]   rs2,
    output logic               taken
);

    always_comb begin
        taken = 1'b0;
        case (cmp_type)
            BEQ:     taken = (rs1 == rs2);
            BNE:     taken = (rs1 != rs2);
            BLT:     taken = ($signed(rs1) <  $signed(rs2));
            BGE:     taken = ($signed(rs1) >= $signed(rs2));
            BLTU:    taken = (rs1 <  rs2);
            BGEU:    taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_seq.sv
// Branch resolution sequencer: captures a branch, evaluates it, issues a fetch redirect + flush.
// Latency: accept -> EVAL next cycle -> redirect/flush the cycle after; one branch per 2 cycles.
// Backpressure: in_ready only in IDLE; redirect held until redir_ready. BRSEQ_PREDICT_EN: redirect on mispredict only.
module branch_seq
    import lib_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  cmp_type_t          in_cmp_type,
    input  logic [WIDTH-1:0]   in_rs1,
    input  logic [WIDTH-1:0]   in_rs2,
    input  logic [WIDTH-1:0]   in_pc,
    input  logic [WIDTH-1:0]   in_imm,
    input  logic               in_pred_taken,
    output logic               redir_valid,
    input  logic               redir_ready,
    output logic [WIDTH-1:0]   redir_pc,
    output logic               flush,
    output logic [15:0]        stat_br,
    output logic [15:0]        stat_redir
);

    brseq_state_t       state_q, state_d;
    cmp_type_t          cmp_type_q, cmp_type_d;
    logic [WIDTH-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
    logic [WIDTH-1:0]   pc_q, pc_d, imm_q, imm_d;
    logic [WIDTH-1:0]   redir_pc_q, redir_pc_d;
    logic               flush_q, flush_d;
    logic [15:0]        stat_br_q, stat_br_d, stat_redir_q, stat_redir_d;

    logic               taken;
    logic               redirect_req;
    logic [WIDTH-1:0]   target;
    logic [WIDTH-1:0]   redirect_pc;

    cmp #(.WIDTH(WIDTH)) cmp (
        .cmp_type (cmp_type_q),
        .rs1      (rs1_q),
        .rs2      (rs2_q),
        .taken    (taken)
    );

    assign target = pc_q + imm_q;

`ifdef BRSEQ_PREDICT_EN
    logic               pred_q, pred_d;
    logic [WIDTH-1:0]   fallthrough;

    assign fallthrough  = pc_q + WIDTH'(PC_STEP);
    assign redirect_req = (taken != pred_q);
    assign redirect_pc  = taken ? target : fallthrough;

    always_comb begin
        pred_d = pred_q;
        if (state_q == IDLE && in_valid) begin
            pred_d = in_pred_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_q <= 1'b0;
        end else begin
            pred_q <= pred_d;
        end
    end
`else
    logic pred_unused;

    assign pred_unused  = in_pred_taken;
    assign redirect_req = taken;
    assign redirect_pc  = target;
`endif

    always_comb begin
        state_d      = state_q;
        cmp_type_d   = cmp_type_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        redir_pc_d   = redir_pc_q;
        flush_d      = 1'b0;
        stat_br_d    = stat_br_q;
        stat_redir_d = stat_redir_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cmp_type_d = in_cmp_type;
                    rs1_d      = in_rs1;
                    rs2_d      = in_rs2;
                    pc_d       = in_pc;
                    imm_d      = in_imm;
                    state_d    = EVAL;
                end
            end
            EVAL: begin
                stat_br_d = sat_inc16(stat_br_q);
                if (redirect_req) begin
                    state_d      = REDIRECT;
                    redir_pc_d   = redirect_pc;
                    flush_d      = 1'b1;
                    stat_redir_d = sat_inc16(stat_redir_q);
                end else begin
                    state_d = IDLE;
                end
            end
            REDIRECT: begin
                // redir_pc returns to zero together with redir_valid
                if (redir_ready) begin
                    state_d    = IDLE;
                    redir_pc_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                redir_pc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmp_type_q   <= BEQ;
            rs1_q        <= '0;
            rs2_q        <= '0;
            pc_q         <= '0;
            imm_q        <= '0;
            redir_pc_q   <= '0;
            flush_q      <= 1'b0;
            stat_br_q    <= '0;
            stat_redir_q <= '0;
        end else begin
            state_q      <= state_d;
            cmp_type_q   <= cmp_type_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
            redir_pc_q   <= redir_pc_d;
            flush_q      <= flush_d;
            stat_br_q    <= stat_br_d;
            stat_redir_q <= stat_redir_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign redir_valid = (state_q == REDIRECT);
    assign redir_pc    = redir_pc_q;
    assign flush       = flush_q;
    assign stat_br     = stat_br_q;
    assign stat_redir  = stat_redir_q;

endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq; expectations adapt when BRSEQ_PREDICT_EN is defined.
module tb_branch_seq;
    import lib_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    cmp_type_t   in_cmp_type;
    logic [31:0] in_rs1, in_rs2, in_pc, in_imm;
    logic        in_pred_taken;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        flush;
    logic [15:0] stat_br, stat_redir;

    int checks = 0;
    int errors = 0;

    branch_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cmp_type  (in_cmp_type),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_pc        (in_pc),
        .in_imm       (in_imm),
        .in_pred_taken(in_pred_taken),
        .redir_valid  (redir_valid),
        .redir_ready  (redir_ready),
        .redir_pc     (redir_pc),
        .flush        (flush),
        .stat_br      (stat_br),
        .stat_redir   (stat_redir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; returns 1ns after the accepting edge.
    task automatic issue(input cmp_type_t t, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        in_valid      = 1'b1;
        in_cmp_type   = t;
        in_rs1        = a;
        in_rs2        = b;
        in_pc         = pc;
        in_imm        = imm;
        in_pred_taken = pred;
        step();
        in_valid      = 1'b0;
        in_pred_taken = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_cmp_type   = BEQ;
        in_rs1        = '0;
        in_rs2        = '0;
        in_pc         = '0;
        in_imm        = '0;
        in_pred_taken = 1'b0;
        redir_ready   = 1'b1;
        #1;
        chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rst_stat_br", {16'd0, stat_br}, 32'd0);
        chk("rst_stat_redir", {16'd0, stat_redir}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // BEQ taken: redirect two edges after accept
        issue(BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        chk("beq_eval_in_ready", {31'd0, in_ready}, 32'd0);
        chk("beq_eval_redir_valid", {31'd0, redir_valid}, 32'd0);
        step();
        chk("beq_redir_valid", {31'd0, redir_valid}, 32'd1);
        chk("beq_redir_pc", redir_pc, 32'h120);
        chk("beq_flush", {31'd0, flush}, 32'd1);
        chk("beq_stat_br", {16'd0, stat_br}, 32'd1);
        chk("beq_stat_redir", {16'd0, stat_redir}, 32'd1);
        step();
        chk("beq_done_valid", {31'd0, redir_valid}, 32'd0);
        chk("beq_done_flush", {31'd0, flush}, 32'd0);
        chk("beq_done_pc_zero", redir_pc, 32'd0);
        chk("beq_done_in_ready", {31'd0, in_ready}, 32'd1);

        // Signed vs unsigned compare of -1 and 1
        issue(BLT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h8, 1'b0);
        step();
        chk("blt_redir_valid", {31'd0, redir_valid}, 32'd1);
        chk("blt_redir_pc", redir_pc, 32'h208);
        step();
        issue(BLTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h8, 1'b0);
        step();
        chk("bltu_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("bltu_flush", {31'd0, flush}, 32'd0);
        chk("bltu_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bltu_stat_br", {16'd0, stat_br}, 32'd3);
        chk("bltu_stat_redir", {16'd0, stat_redir}, 32'd2);

        // Redirect stalled by fetch for 5 cycles; negative offset
        redir_ready = 1'b0;
        issue(BGE, 32'd7, 32'd3, 32'h300, 32'hFFFF_FFF0, 1'b0);
        step();
        chk("stall_first_valid", {31'd0, redir_valid}, 32'd1);
        chk("stall_first_flush", {31'd0, flush}, 32'd1);
        chk("stall_first_pc", redir_pc, 32'h2F0);
        chk("stall_first_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_valid", {31'd0, redir_valid}, 32'd1);
            chk("stall_flush", {31'd0, flush}, 32'd0);
            chk("stall_pc", redir_pc, 32'h2F0);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        redir_ready = 1'b1;
        step();
        chk("stall_release_valid", {31'd0, redir_valid}, 32'd0);
        chk("stall_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("stall_stat_redir", {16'd0, stat_redir}, 32'd3);

        // Target wraps past 2^32
        issue(BNE, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, 1'b0);
        step();
        chk("wrap_redir_valid", {31'd0, redir_valid}, 32'd1);
        chk("wrap_redir_pc", redir_pc, 32'h0000_0010);
        step();

        // Undefined compare encoding is never taken
        issue(cmp_type_t'(3'd2), 32'd9, 32'd9, 32'h500, 32'h40, 1'b0);
        step();
        chk("undef_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("undef_stat_br", {16'd0, stat_br}, 32'd6);
        chk("undef_stat_redir", {16'd0, stat_redir}, 32'd4);

        // Predicted-taken on a not-taken BGE
        issue(BGE, 32'd1, 32'd5, 32'h40, 32'h100, 1'b1);
        step();
`ifdef BRSEQ_PREDICT_EN
        chk("pred_nt_redir_valid", {31'd0, redir_valid}, 32'd1);
        chk("pred_nt_redir_pc", redir_pc, 32'h44);
        step();
`else
        chk("pred_nt_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("pred_nt_redir_pc", redir_pc, 32'd0);
`endif

        // Predicted-taken on a taken BEQ
        issue(BEQ, 32'd5, 32'd5, 32'h80, 32'h10, 1'b1);
        step();
`ifdef BRSEQ_PREDICT_EN
        chk("pred_t_redir_valid", {31'd0, redir_valid}, 32'd0);
`else
        chk("pred_t_redir_valid", {31'd0, redir_valid}, 32'd1);
        chk("pred_t_redir_pc", redir_pc, 32'h90);
        step();
`endif
        chk("pred_stat_br", {16'd0, stat_br}, 32'd8);
        chk("pred_stat_redir", {16'd0, stat_redir}, 32'd5);

        // Reset asserted mid-REDIRECT clears everything asynchronously
        redir_ready = 1'b0;
        issue(BNE, 32'd3, 32'd4, 32'h600, 32'h20, 1'b0);
        step();
        chk("prerst_redir_valid", {31'd0, redir_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("arst_flush", {31'd0, flush}, 32'd0);
        chk("arst_redir_pc", redir_pc, 32'd0);
        chk("arst_stat_br", {16'd0, stat_br}, 32'd0);
        chk("arst_stat_redir", {16'd0, stat_redir}, 32'd0);
        step();
        rst_n = 1'b1;
        redir_ready = 1'b1;
        step();
        chk("arst_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_release_valid", {31'd0, redir_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
